// File: rtl/mod14_pkg.sv
// Shared types and helpers for the mod-14 counter family.
// Holds the monitor FSM states, step classes and modulo helpers.
package mod14_pkg;

    localparam int         MOD14_W   = 4;
    localparam logic [3:0] MOD14_MAX = 4'd13;

    typedef enum logic [1:0] {
        UNLOCKED,
        ACQUIRE,
        LOCKED
    } mon_state_t;

    typedef enum logic [2:0] {
        UP,
        DOWN,
        HOLD,
        SKIP,
        ILLEGAL
    } step_class_t;

    function automatic logic [MOD14_W-1:0] mod14_inc(
        input logic [MOD14_W-1:0] v
    );
        return (v >= MOD14_MAX) ? '0 : v + 4'd1;
    endfunction

    function automatic logic [MOD14_W-1:0] mod14_dec(
        input logic [MOD14_W-1:0] v
    );
        return (v == '0) ? MOD14_MAX : v - 4'd1;
    endfunction

endpackage

// File: rtl/mod14_step_classify.sv
// Classifies one mod-14 sample against the previous accepted value.
// Purely combinational; illegal codes win over every other class.
module mod14_step_classify
    import mod14_pkg::*;
(
    input  logic [MOD14_W-1:0] prev,
    input  logic [MOD14_W-1:0] count_in,
    output step_class_t        cls,
    output logic               wrap_up,
    output logic               wrap_dn
);

    // Priority: illegal, then +1, -1, hold, otherwise a skip.
    always_comb begin
        cls = SKIP;
        if (count_in > MOD14_MAX) begin
            cls = ILLEGAL;
        end else if (count_in == mod14_inc(prev)) begin
            cls = UP;
        end else if (count_in == mod14_dec(prev)) begin
            cls = DOWN;
        end else if (count_in == prev) begin
            cls = HOLD;
        end
    end

    assign wrap_up = (cls == UP)   && (prev == MOD14_MAX);
    assign wrap_dn = (cls == DOWN) && (prev == '0);

endmodule

// File: rtl/mod14_count_monitor.sv
// Lock-on monitor for a mod-14 count stream with wrap tracking.
// Define MOD14_MON_WRAP_CNT_EN to build the signed wrap accumulator.
module mod14_count_monitor
    import mod14_pkg::*;
#(
    parameter int WRAP_W  = 8,
    parameter int LOCK_N  = 3,
    parameter int ERR_MAX = 2
) (
    input  logic                     clock,
    input  logic                     rest,
    input  logic                     count_valid,
    input  logic [MOD14_W-1:0]       count_in,
    output logic                     locked,
    output logic                     dir,
    output logic                     step,
    output logic                     wrap_up,
    output logic                     wrap_dn,
    output logic                     skip_err,
    output logic                     illegal_err,
    output logic                     lost,
    output logic signed [WRAP_W-1:0] wrap_count
);

    localparam logic [2:0] LOCK_C = 3'(LOCK_N);
    localparam logic [2:0] ERR_C  = 3'(ERR_MAX);

    mon_state_t         state_q;
    mon_state_t         state_nxt;
    logic [MOD14_W-1:0] prev_q;
    logic [MOD14_W-1:0] prev_nxt;
    logic [2:0]         good_q;
    logic [2:0]         good_nxt;
    logic [2:0]         good_inc;
    logic [2:0]         err_q;
    logic [2:0]         err_nxt;
    logic [2:0]         err_inc;
    logic               dir_nxt;
    logic               step_nxt;
    logic               wup_nxt;
    logic               wdn_nxt;
    logic               skip_nxt;
    logic               ill_nxt;
    logic               lost_nxt;
    step_class_t        cls;
    logic               cls_wup;
    logic               cls_wdn;

    mod14_step_classify u_classify (
        .prev     (prev_q),
        .count_in (count_in),
        .cls      (cls),
        .wrap_up  (cls_wup),
        .wrap_dn  (cls_wdn)
    );

    assign good_inc = good_q + 3'd1;
    assign err_inc  = err_q + 3'd1;

    // Next state, counters and pulse requests for the current sample.
    always_comb begin
        state_nxt = state_q;
        prev_nxt  = prev_q;
        good_nxt  = good_q;
        err_nxt   = err_q;
        dir_nxt   = dir;
        step_nxt  = 1'b0;
        wup_nxt   = 1'b0;
        wdn_nxt   = 1'b0;
        skip_nxt  = 1'b0;
        ill_nxt   = 1'b0;
        lost_nxt  = 1'b0;
        if (count_valid) begin
            unique case (state_q)
                UNLOCKED: begin
                    if (cls == ILLEGAL) begin
                        ill_nxt = 1'b1;
                    end else begin
                        prev_nxt  = count_in;
                        good_nxt  = '0;
                        state_nxt = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    unique case (cls)
                        UP, DOWN: begin
                            prev_nxt = count_in;
                            good_nxt = good_inc;
                            if (good_inc >= LOCK_C) begin
                                state_nxt = LOCKED;
                                err_nxt   = '0;
                            end
                        end
                        SKIP: begin
                            skip_nxt = 1'b1;
                            prev_nxt = count_in;
                            good_nxt = '0;
                        end
                        ILLEGAL: begin
                            ill_nxt   = 1'b1;
                            state_nxt = UNLOCKED;
                        end
                        default: begin
                        end
                    endcase
                end
                LOCKED: begin
                    unique case (cls)
                        UP, DOWN: begin
                            step_nxt = 1'b1;
                            dir_nxt  = (cls == UP);
                            wup_nxt  = cls_wup;
                            wdn_nxt  = cls_wdn;
                            prev_nxt = count_in;
                            err_nxt  = '0;
                        end
                        SKIP: begin
                            skip_nxt = 1'b1;
                            prev_nxt = count_in;
                            err_nxt  = err_inc;
                        end
                        ILLEGAL: begin
                            ill_nxt = 1'b1;
                            err_nxt = err_inc;
                        end
                        default: begin
                        end
                    endcase
                    if (err_nxt >= ERR_C) begin
                        lost_nxt  = 1'b1;
                        state_nxt = UNLOCKED;
                    end
                end
                default: begin
                    state_nxt = UNLOCKED;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (rest) begin
            state_q     <= UNLOCKED;
            prev_q      <= '0;
            good_q      <= '0;
            err_q       <= '0;
            locked      <= 1'b0;
            dir         <= 1'b0;
            step        <= 1'b0;
            wrap_up     <= 1'b0;
            wrap_dn     <= 1'b0;
            skip_err    <= 1'b0;
            illegal_err <= 1'b0;
            lost        <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            prev_q      <= prev_nxt;
            good_q      <= good_nxt;
            err_q       <= err_nxt;
            locked      <= (state_nxt == LOCKED);
            dir         <= dir_nxt;
            step        <= step_nxt;
            wrap_up     <= wup_nxt;
            wrap_dn     <= wdn_nxt;
            skip_err    <= skip_nxt;
            illegal_err <= ill_nxt;
            lost        <= lost_nxt;
        end
    end

`ifdef MOD14_MON_WRAP_CNT_EN
    localparam logic signed [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

    logic signed [WRAP_W-1:0] wrap_q;

    // Signed wrap accumulator; wraps freely and survives lock loss.
    always_ff @(posedge clock) begin
        if (rest) begin
            wrap_q <= '0;
        end else if (wup_nxt) begin
            wrap_q <= wrap_q + WRAP_ONE;
        end else if (wdn_nxt) begin
            wrap_q <= wrap_q - WRAP_ONE;
        end
    end

    assign wrap_count = wrap_q;
`else
    assign wrap_count = '0;
`endif

endmodule

// File: tb/tb_mod14_count_monitor.sv
// Self-checking bench for mod14_count_monitor.
// Directed scenarios plus a randomized run against a behavioural model.
module tb_mod14_count_monitor;

    localparam int WRAP_W  = 8;
    localparam int LOCK_N  = 3;
    localparam int ERR_MAX = 2;
`ifdef MOD14_MON_WRAP_CNT_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              rest = 1'b1;
    logic              count_valid = 1'b0;
    logic [3:0]        count_in = 4'd0;
    logic              locked;
    logic              dir;
    logic              step;
    logic              wrap_up;
    logic              wrap_dn;
    logic              skip_err;
    logic              illegal_err;
    logic              lost;
    logic signed [7:0] wrap_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: state 0=unlocked 1=acquire 2=locked
    int m_state = 0;
    int m_prev  = 0;
    int m_good  = 0;
    int m_err   = 0;
    int m_wrap  = 0;
    bit e_locked, e_dir, e_step, e_wup, e_wdn;
    bit e_skip, e_ill, e_lost;

    mod14_count_monitor #(
        .WRAP_W  (WRAP_W),
        .LOCK_N  (LOCK_N),
        .ERR_MAX (ERR_MAX)
    ) dut (
        .clock       (clock),
        .rest        (rest),
        .count_valid (count_valid),
        .count_in    (count_in),
        .locked      (locked),
        .dir         (dir),
        .step        (step),
        .wrap_up     (wrap_up),
        .wrap_dn     (wrap_dn),
        .skip_err    (skip_err),
        .illegal_err (illegal_err),
        .lost        (lost),
        .wrap_count  (wrap_count)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] exp_wrap();
        return WRAP_EN ? 8'(m_wrap) : 8'd0;
    endfunction

    function automatic logic [15:0] dut_vec();
        return {locked, dir, step, wrap_up, wrap_dn,
                skip_err, illegal_err, lost, wrap_count};
    endfunction

    function automatic logic [15:0] exp_vec();
        return {e_locked, e_dir, e_step, e_wup, e_wdn,
                e_skip, e_ill, e_lost, exp_wrap()};
    endfunction

    // One clock: drive inputs, advance the model, sample after the edge.
    task automatic cyc(input bit r, input bit v, input int d);
        int up_v;
        int dn_v;
        bit bad;
        @(negedge clock);
        rest        = r;
        count_valid = v;
        count_in    = 4'(d);
        @(posedge clock);
        up_v = (m_prev + 1) % 14;
        dn_v = (m_prev + 13) % 14;
        bad  = (d >= 14);
        {e_step, e_wup, e_wdn, e_skip, e_ill, e_lost} = '0;
        if (r) begin
            m_state = 0; m_prev = 0; m_good = 0;
            m_err = 0; m_wrap = 0; e_dir = 0;
        end else if (v) begin
            case (m_state)
                0: begin
                    if (bad) e_ill = 1;
                    else begin
                        m_prev = d; m_good = 0; m_state = 1;
                    end
                end
                1: begin
                    if (bad) begin
                        e_ill = 1; m_state = 0;
                    end else if (d == up_v || d == dn_v) begin
                        m_prev = d;
                        m_good++;
                        if (m_good == LOCK_N) begin
                            m_state = 2; m_err = 0;
                        end
                    end else if (d != m_prev) begin
                        e_skip = 1; m_prev = d; m_good = 0;
                    end
                end
                default: begin
                    if (bad) begin
                        e_ill = 1; m_err++;
                    end else if (d == up_v || d == dn_v) begin
                        e_step = 1;
                        e_dir  = (d == up_v);
                        if (d == up_v && d == 0) begin
                            e_wup = 1; m_wrap++;
                        end
                        if (d == dn_v && d == 13) begin
                            e_wdn = 1; m_wrap--;
                        end
                        m_prev = d; m_err = 0;
                    end else if (d != m_prev) begin
                        e_skip = 1; m_prev = d; m_err++;
                    end
                    if (m_err >= ERR_MAX) begin
                        e_lost = 1; m_state = 0;
                    end
                end
            endcase
        end
        e_locked = (m_state == 2);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0);
        cyc(1, 1, 5);
        n_checks++;
        if (dut_vec() !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0000", dut_vec());
        end
    endtask

    task automatic test_lock();
        int seq[4] = '{0, 1, 2, 3};
        cyc(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, seq[i]);
            n_checks++;
            if (locked !== (i == 3) || step !== 1'b0) begin
                n_fail++;
                $display("FAIL lock_seq[%0d]: locked=%b step=%b want %b/0",
                         i, locked, step, i == 3);
            end
        end
        n_checks++;
        if (wrap_count !== 8'sd0) begin
            n_fail++;
            $display("FAIL lock_wrap: got %0d want 0", wrap_count);
        end
    endtask

    task automatic test_wrap_up();
        int seq[3] = '{13, 0, 1};
        cyc(1, 0, 0);
        for (int i = 9; i <= 12; i++) cyc(0, 1, i);
        cyc(0, 0, 7);
        n_checks++;
        if (locked !== 1'b1 || step !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_low_hold: locked=%b step=%b want 1/0",
                     locked, step);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, seq[i]);
            n_checks++;
            if (step !== 1'b1 || dir !== 1'b1 || wrap_up !== (i == 1)) begin
                n_fail++;
                $display("FAIL wrap_up[%0d]: step=%b dir=%b wup=%b want 1/1/%b",
                         i, step, dir, wrap_up, i == 1);
            end
        end
        n_checks++;
        if (wrap_count !== (WRAP_EN ? 8'sd1 : 8'sd0)) begin
            n_fail++;
            $display("FAIL wrap_up_count: got %0d want %0d",
                     wrap_count, WRAP_EN ? 1 : 0);
        end
    endtask

    task automatic test_wrap_dn();
        int seq[3] = '{0, 13, 12};
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, seq[i]);
            n_checks++;
            if (step !== 1'b1 || dir !== 1'b0 || wrap_dn !== (i == 1)) begin
                n_fail++;
                $display("FAIL wrap_dn[%0d]: step=%b dir=%b wdn=%b want 1/0/%b",
                         i, step, dir, wrap_dn, i == 1);
            end
        end
        n_checks++;
        if (wrap_count !== 8'sd0) begin
            n_fail++;
            $display("FAIL wrap_dn_count: got %0d want 0", wrap_count);
        end
    endtask

    task automatic test_err_lost();
        cyc(1, 0, 0);
        for (int i = 2; i <= 5; i++) cyc(0, 1, i);
        cyc(0, 1, 9);
        n_checks++;
        if ({skip_err, illegal_err, lost, locked} !== 4'b1001) begin
            n_fail++;
            $display("FAIL err_skip: got %b want 1001",
                     {skip_err, illegal_err, lost, locked});
        end
        cyc(0, 1, 15);
        n_checks++;
        if ({skip_err, illegal_err, lost, locked} !== 4'b0110) begin
            n_fail++;
            $display("FAIL err_lost: got %b want 0110",
                     {skip_err, illegal_err, lost, locked});
        end
    endtask

    task automatic test_acquire_skip();
        cyc(1, 0, 0);
        for (int i = 2; i <= 4; i++) cyc(0, 1, i);
        cyc(0, 1, 7);
        n_checks++;
        if (skip_err !== 1'b1 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL acq_skip: skip=%b locked=%b want 1/0",
                     skip_err, locked);
        end
        for (int i = 8; i <= 10; i++) begin
            cyc(0, 1, i);
            n_checks++;
            if (locked !== (i == 10) || step !== 1'b0) begin
                n_fail++;
                $display("FAIL acq_relock[%0d]: locked=%b step=%b want %b/0",
                         i, locked, step, i == 10);
            end
        end
    endtask

    task automatic test_reset_midstream();
        cyc(1, 0, 0);
        for (int i = 10; i <= 13; i++) cyc(0, 1, i);
        cyc(0, 1, 0);
        cyc(1, 1, 14);
        n_checks++;
        if (dut_vec() !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h want 0000", dut_vec());
        end
        cyc(0, 0, 3);
        n_checks++;
        if (dut_vec() !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_after: got %h want 0000", dut_vec());
        end
    endtask

    task automatic test_random();
        int d;
        int p;
        bit r;
        bit v;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom % 300) == 0;
            v = ($urandom % 8) != 0;
            p = $urandom % 10;
            if (p < 6)
                d = ($urandom % 2) ? (m_prev + 1) % 14 : (m_prev + 13) % 14;
            else if (p == 6)
                d = m_prev;
            else if (p == 7)
                d = $urandom_range(0, 13);
            else if (p == 8)
                d = $urandom_range(0, 15);
            else
                d = $urandom_range(14, 15);
            cyc(r, v, d);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", n,
                         dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_wrap_up();
        test_wrap_dn();
        test_err_lost();
        test_acquire_skip();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
